// File: rtl/fir_sym_mac_if.sv
// fir_sym_mac_if: sample strobe, tap bus, coefficient write port and result signals
// of the symmetric FIR multiply-accumulate block.
interface fir_sym_mac_if #(
   parameter int COEF_W = 16,
   parameter int OUT_W  = 16
);
   logic                     iEnSample_600k;
   logic                     iEnMac;
   logic [98:0]              iTaps;
   logic                     iCoeffWr;
   logic [4:0]               iCoeffAddr;
   logic signed [COEF_W-1:0] iCoeffData;
   logic signed [OUT_W-1:0]  oFirOut;
   logic                     oValid;
   logic                     oBusy;
   logic                     oOverrun;
   modport master (
      output iEnSample_600k, iEnMac, iTaps, iCoeffWr, iCoeffAddr, iCoeffData,
      input  oFirOut, oValid, oBusy, oOverrun
   );
   modport slave (
      input  iEnSample_600k, iEnMac, iTaps, iCoeffWr, iCoeffAddr, iCoeffData,
      output oFirOut, oValid, oBusy, oOverrun
   );
endinterface

// File: rtl/fir_sym_mac.sv
// fir_sym_mac: folds the 33 symmetric taps into 17 pre-adds and runs one MAC per clock,
// producing one rounded, saturated sample per 600 kHz strobe.
module fir_sym_mac #(
   parameter int COEF_W = 16,
   parameter int ACC_W  = 25,
   parameter int OUT_W  = 16,
   parameter int SHIFT  = 9
) (
   input logic          iClk_12M,
   input logic          iRst,
   fir_sym_mac_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
   localparam logic signed [ACC_W:0] HALF = ((ACC_W+1)'(1) << SHIFT) >> 1;
   localparam logic signed [ACC_W:0] MAX  = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
   localparam logic signed [ACC_W:0] MIN  = ~MAX;
   state_t                   state, state_nxt;
   logic                     r_start;
   logic                     strobe;
   logic [4:0]               idx;
   logic [98:0]              snap;
   logic signed [ACC_W-1:0]  acc;
   logic signed [COEF_W-1:0] coef [17];
   logic signed [OUT_W-1:0]  fir_out;
   logic                     valid;
   logic                     overrun;
   logic [6:0]               lo_a, lo_b;
   logic signed [2:0]        tap_a, tap_b;
   logic signed [3:0]        pre;
   logic signed [COEF_W+3:0] prod;
   logic signed [ACC_W:0]    rnd;
   logic signed [OUT_W-1:0]  sat;

   assign strobe = bus.iEnSample_600k && bus.iEnMac;
   // term idx pairs tap idx+1 with its mirror tap 33-idx; the centre tap 17 stands alone
   assign lo_a  = 7'(3 * idx);
   assign lo_b  = 7'(96 - 3 * idx);
   assign tap_a = snap[lo_a +: 3];
   assign tap_b = snap[lo_b +: 3];
   assign pre   = 4'(tap_a) + (idx == 5'd16 ? 4'sd0 : 4'(tap_b));
   assign prod  = pre * coef[idx];
   assign rnd   = ($signed({acc[ACC_W-1], acc}) + HALF) >>> SHIFT;
   assign sat   = rnd > MAX ? OUT_W'(MAX) : rnd < MIN ? OUT_W'(MIN) : OUT_W'(rnd);

   always_ff @(posedge iClk_12M) state <= iRst ? IDLE : state_nxt;

   always_comb begin
      state_nxt = IDLE;
      state_nxt = state == IDLE ? (r_start ? MAC : IDLE) :
                  state == MAC  ? (idx == 5'd16 ? OUT : MAC) : IDLE;
   end

   always_ff @(posedge iClk_12M) begin
      if (iRst) begin
         r_start <= 1'b0;
         idx     <= '0;
         snap    <= '0;
         acc     <= '0;
         fir_out <= '0;
         valid   <= 1'b0;
         overrun <= 1'b0;
         for (int i = 0; i < 17; i++) coef[i] <= '0;
      end else begin
         r_start <= strobe && state == IDLE && !r_start;
         overrun <= overrun || (strobe && (state != IDLE || r_start));
         valid   <= state == OUT;
         if (state == IDLE && r_start) begin
            snap <= bus.iTaps;
            acc  <= '0;
            idx  <= '0;
         end
         if (state == MAC) begin
            acc <= acc + ACC_W'(prod);
            idx <= idx == 5'd16 ? idx : idx + 5'd1;
         end
         if (state == OUT) fir_out <= sat;
         if (bus.iCoeffWr && state == IDLE && !r_start && bus.iCoeffAddr <= 5'd16)
            coef[bus.iCoeffAddr] <= bus.iCoeffData;
      end
   end

   assign bus.oFirOut  = fir_out;
   assign bus.oValid   = valid;
   assign bus.oBusy    = state != IDLE;
   assign bus.oOverrun = overrun;
endmodule

// File: tb/tb_fir_sym_mac.sv
// tb_fir_sym_mac: drives a SHIFT=9 and a SHIFT=0 instance from the same stimulus and
// checks both against an arithmetic model of the folded FIR sum.
module tb_fir_sym_mac;
   logic iClk_12M = 1'b0;
   logic iRst;
   int   n_checks = 0;
   int   n_fail = 0;
   int   tap_m [1:33];
   int   coef_m [17];
   int   ovr_m, last9, last0;

   typedef struct {
      int tap_all;
      int tap17;
      int coef_all;
      int coef16;
      int exp9;
      int exp0;
   } vec_t;
   vec_t vecs [8];

   fir_sym_mac_if b9 ();
   fir_sym_mac_if b0 ();
   fir_sym_mac #(.SHIFT(9)) dut9 (.iClk_12M(iClk_12M), .iRst(iRst), .bus(b9.slave));
   fir_sym_mac #(.SHIFT(0)) dut0 (.iClk_12M(iClk_12M), .iRst(iRst), .bus(b0.slave));

   assign b0.iEnSample_600k = b9.iEnSample_600k;
   assign b0.iEnMac         = b9.iEnMac;
   assign b0.iTaps          = b9.iTaps;
   assign b0.iCoeffWr       = b9.iCoeffWr;
   assign b0.iCoeffAddr     = b9.iCoeffAddr;
   assign b0.iCoeffData     = b9.iCoeffData;

   always #5 iClk_12M = ~iClk_12M;

   task automatic step;
      @(posedge iClk_12M);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [98:0] pack_taps();
      logic [98:0] p;
      p = '0;
      for (int k = 1; k <= 33; k++) p[3*k-1 -: 3] = 3'(tap_m[k]);
      return p;
   endfunction

   // y = sum over all 33 taps of tap*h, with h symmetric about tap 17
   function automatic int model(input int shift);
      longint acc, r;
      acc = 0;
      for (int k = 1; k <= 33; k++)
         acc += longint'(tap_m[k]) * coef_m[k <= 17 ? k - 1 : 33 - k];
      if (shift > 0) r = (acc + (longint'(1) << (shift - 1))) >>> shift;
      else r = acc;
      return r > 32767 ? 32767 : r < -32768 ? -32768 : int'(r);
   endfunction

   task automatic wr(input int addr, input int data);
      b9.iCoeffWr   = 1'b1;
      b9.iCoeffAddr = 5'(addr);
      b9.iCoeffData = 16'(data);
      step;
      b9.iCoeffWr = 1'b0;
      if (addr <= 16) coef_m[addr] = data;
   endtask

   task automatic fill(input int v);
      for (int k = 1; k <= 33; k++) tap_m[k] = v;
   endtask

   task automatic fill_rand;
      for (int k = 1; k <= 33; k++) tap_m[k] = int'($urandom_range(0, 7)) - 4;
   endtask

   task automatic push(input int v);
      for (int k = 33; k >= 2; k--) tap_m[k] = tap_m[k-1];
      tap_m[1] = v;
   endtask

   // One 20-clock sample period; event arguments are edge numbers after the strobe edge E0
   task automatic sample(input bit en, input int exp9, input int exp0, input int strobe2,
                         input int wr_at, input int wr_addr, input int wr_data,
                         input int rst_at, input int en_drop);
      int pulses, pos;
      bit expv;
      expv   = en && rst_at < 0;
      pulses = 0;
      pos    = -1;
      b9.iTaps          = pack_taps();
      b9.iEnMac         = en;
      b9.iEnSample_600k = 1'b1;
      for (int c = 0; c < 20; c++) begin
         step;
         if (b9.oValid || b0.oValid) begin
            pulses++;
            pos = c;
         end
         if (c == strobe2 - 1 && en && b9.iEnMac) ovr_m = 1;
         b9.iEnSample_600k = (c == strobe2 - 1);
         b9.iCoeffWr       = (c == wr_at - 1);
         b9.iCoeffAddr     = 5'(wr_addr);
         b9.iCoeffData     = 16'(wr_data);
         iRst              = (c == rst_at - 1);
         if (c == en_drop) b9.iEnMac = 1'b0;
         if (c == 1 && rst_at != 1) check("busy_after_snapshot", int'(b9.oBusy), int'(en));
         if (c == rst_at) begin
            check("rst_mid_out9", int'(b9.oFirOut), 0);
            check("rst_mid_out0", int'(b0.oFirOut), 0);
            check("rst_mid_busy", int'(b9.oBusy), 0);
            check("rst_mid_overrun", int'(b9.oOverrun), 0);
            for (int j = 0; j < 17; j++) coef_m[j] = 0;
            ovr_m = 0;
            last9 = 0;
            last0 = 0;
         end
      end
      check("valid_pulses", pulses, expv ? 1 : 0);
      if (expv) check("valid_latency", pos, 19);
      check("out_shift9", int'(b9.oFirOut), expv ? exp9 : last9);
      check("out_shift0", int'(b0.oFirOut), expv ? exp0 : last0);
      check("overrun9", int'(b9.oOverrun), ovr_m);
      check("overrun0", int'(b0.oOverrun), ovr_m);
      check("busy_idle", int'(b9.oBusy), 0);
      if (expv) begin
         last9 = exp9;
         last0 = exp0;
      end
   endtask

   initial begin
      vecs[0] = '{-4, -4, 32767, 32767, -8448, -32768};
      vecs[1] = '{-4, -4, -32768, -32768, 8448, 32767};
      vecs[2] = '{0, 1, 0, 256, 1, 256};
      vecs[3] = '{0, 1, 0, 255, 0, 255};
      vecs[4] = '{0, -1, 0, 256, 0, -256};
      vecs[5] = '{0, -1, 0, 257, -1, -257};
      vecs[6] = '{3, 3, 32767, 32767, 6336, 32767};
      vecs[7] = '{-4, -4, 1, 1, 0, -132};
      iRst              = 1'b1;
      b9.iEnSample_600k = 1'b0;
      b9.iEnMac         = 1'b1;
      b9.iTaps          = '0;
      b9.iCoeffWr       = 1'b0;
      b9.iCoeffAddr     = '0;
      b9.iCoeffData     = '0;
      for (int j = 0; j < 17; j++) coef_m[j] = 0;
      fill(0);
      ovr_m = 0;
      last9 = 0;
      last0 = 0;
      step;
      step;
      iRst = 1'b0;
      check("reset_out9", int'(b9.oFirOut), 0);
      check("reset_out0", int'(b0.oFirOut), 0);
      check("reset_valid", int'(b9.oValid), 0);
      check("reset_busy", int'(b9.oBusy), 0);
      check("reset_overrun", int'(b9.oOverrun), 0);

      foreach (vecs[i]) begin
         for (int j = 0; j < 16; j++) wr(j, vecs[i].coef_all);
         wr(16, vecs[i].coef16);
         fill(vecs[i].tap_all);
         tap_m[17] = vecs[i].tap17;
         sample(1, vecs[i].exp9, vecs[i].exp0, -1, -1, 0, 0, -1, -1);
      end

      for (int j = 0; j < 17; j++) wr(j, 512 * (j + 1));
      fill(0);
      for (int i = 0; i < 35; i++) begin
         int k, h;
         push(i == 0 ? 1 : 0);
         k = i + 1;
         h = k > 33 ? 0 : k <= 17 ? k : 34 - k;
         sample(1, h, 512 * h, -1, -1, 0, 0, -1, -1);
      end

      fill_rand;
      sample(1, model(9), model(0), 5, -1, 0, 0, -1, -1);
      push(2);
      sample(1, model(9), model(0), -1, -1, 0, 0, -1, -1);
      sample(0, 0, 0, 5, -1, 0, 0, -1, -1);
      push(-3);
      sample(1, model(9), model(0), -1, -1, 0, 0, -1, 3);

      fill(0);
      tap_m[1] = 1;
      sample(1, model(9), model(0), -1, 5, 0, 1000, -1, -1);
      wr(0, 1000);
      sample(1, model(9), model(0), -1, -1, 0, 0, -1, -1);

      fill(1);
      sample(1, 0, 0, -1, -1, 0, 0, 10, -1);
      sample(1, model(9), model(0), -1, -1, 0, 0, -1, -1);

      for (int r = 0; r < 6; r++) begin
         for (int j = 0; j < 17; j++) wr(j, int'($urandom_range(0, 65535)) - 32768);
         wr(17 + int'($urandom_range(0, 14)), 99);
         fill_rand;
         sample(1, model(9), model(0), -1, -1, 0, 0, -1, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fir_sym_mac.md
Name: fir_sym_mac

Overview:
- Downstream consumer of the 33-tap delay chain in the direct-form FIR (Kaiser window).
- Once per 600 kHz sample it snapshots all 33 taps and folds the symmetric pairs into 17 pre-adds.
- It runs one multiply-accumulate per 12 MHz clock against a programmable 17-entry coefficient bank.
- It emits one rounded, saturated FIR output sample with a 1-cycle valid pulse; the whole computation fits within the 20-clock sample period.

Parameters:
COEF_W, 16, signed coefficient width
ACC_W, 25, accumulator width (4-bit pre-add + COEF_W + 5 growth bits for 17 terms)
OUT_W, 16, output sample width
SHIFT, 9, arithmetic right shift applied to accumulator before saturation (0 allowed)

Ports:
iClk_12M  in  1  system clock, 12 MHz
iRst  in  1  reset; synchronous, active-high
iEnSample_600k  in  1  sample strobe, 1 clock wide, every 20 clocks (same strobe that advances the delay chain)
iEnMac  in  1  block enable; when low, strobes are ignored
iTaps  in  99  packed signed 3-bit taps; tap k (1..33) = iTaps[3k-1:3k-3]
iCoeffWr  in  1  coefficient write strobe
iCoeffAddr  in  5  coefficient index 0..16
iCoeffData  in  COEF_W  signed coefficient value
oFirOut  out  OUT_W  signed filter output, held between updates
oValid  out  1  1-clock pulse when oFirOut updates
oBusy  out  1  high from snapshot edge through output edge
oOverrun  out  1  sticky: strobe arrived while busy

Behaviour:
- Reset (iRst=1 at a clock edge) clears oFirOut=0, oValid=0, oBusy=0, oOverrun=0, accumulator=0, index=0, FSM=IDLE and all 17 coefficients=0. It overrides everything, including mid-MAC; the aborted sample produces no oValid.
- Strobe delay: the delay chain loads at the strobe edge E0, so the block registers the strobe (rStart) at E0 and uses the new taps one edge later.
- FSM states: IDLE, MAC, OUT.
  - IDLE: rStart=1 at edge E1 -> snapshot all 33 taps, acc=0, idx=0, go to MAC, oBusy=1.
  - MAC: edges E2..E18, one term per edge, idx 0..16. At idx 16 -> OUT.
  - OUT: edge E19 -> oFirOut updated, oValid=1 for the following cycle, oBusy=0, go to IDLE.
  - Result: output latency is 19 clocks from the strobe cycle. The next strobe at E20 is accepted normally.
- Term j=0..15: pre = sext(tap[j+1]) + sext(tap[33-j]), 4-bit signed. Term 16: pre = sext(tap[17]). acc += pre * coef[j], signed, full precision into ACC_W.
- Output arithmetic:
  - If SHIFT>0, r = (acc + 2^(SHIFT-1)) >>> SHIFT (round half up); else r = acc.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Strobe gating:
  - Strobe with iEnMac=1 while rStart=1 or FSM != IDLE: ignored and oOverrun is set. The in-flight computation is unaffected.
  - Strobe with iEnMac=0: ignored, no overrun. Deasserting iEnMac mid-MAC does not abort the sample.
- Coefficient writes:
  - Accepted only when oBusy=0 and rStart=0; otherwise silently dropped.
  - iCoeffAddr > 16 is dropped.
  - A write accepted at edge E takes effect for any sample snapshotted after E.
- Between updates oFirOut holds its last value. oValid is never high for more than one consecutive cycle.

Test Plan:
- Impulse response: coef[j]=512*(j+1); iFirIn sequence 1,0,0,... (tap k=1 for exactly one snapshot, k=1..33) -> 33 consecutive oValid outputs 1,2,...,16,17,16,...,2,1, then 0; each oValid 19 clocks after its strobe.
- Saturation, SHIFT=0: all coef=32767, all taps=-4 -> acc=-16*8*32767-4*32767=-4325244, oFirOut=-32768. Repeat with all coef=-32768 -> oFirOut=32767.
- Rounding: SHIFT=9, coef[16]=256, all other coef 0, tap17=1, all other taps 0 -> acc=256 -> (256+256)>>>9 = oFirOut=1. Same setup with coef[16]=255 -> oFirOut=0.
- Overrun: second strobe 5 clocks after the first -> oOverrun=1 sticky; first result still correct; only one oValid. iEnMac=0 with strobes -> no oValid, no overrun.
- Reset mid-MAC: assert iRst at E10 -> no oValid, all outputs 0, coefficients 0. The next strobe after release gives oFirOut=0 with oValid at +19.
- Coefficient write during busy: write coef[0]=1000 at E5 -> dropped, readback via an impulse shows the old value. The same write while idle is applied to the next sample.
